// File: rtl/ppu_pkg.sv
// Shared encodings for the PPU sequencer: mode values, CPU register map and bit positions.
package ppu_pkg;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_XFER   = 2'd3
  } mode_e;

  localparam logic [15:0] ADDR_LCDC = 16'hFF40;
  localparam logic [15:0] ADDR_STAT = 16'hFF41;
  localparam logic [15:0] ADDR_LY   = 16'hFF44;
  localparam logic [15:0] ADDR_LYC  = 16'hFF45;

  localparam int unsigned LCDC_ENABLE = 7;
  localparam int unsigned STAT_EN_LSB = 3;
  localparam int unsigned STAT_EN_MSB = 6;

  localparam logic [7:0] LCDC_RESET = 8'h91;

endpackage

// File: rtl/ppu_stat_irq.sv
// STAT interrupt: masks the mode/coincidence sources, ORs them and pulses on the rising edge.
module ppu_stat_irq
  import ppu_pkg::*;
(
    input  logic       clockgb,
    input  logic       reset,
    input  logic       clear,
    input  logic [3:0] en,
    input  mode_e      mode,
    input  logic       coinc,
    output logic       irq_stat
);

    logic line;
    logic line_q;

    always_comb begin
        line = (en[0] & (mode == MODE_HBLANK)) |
               (en[1] & (mode == MODE_VBLANK)) |
               (en[2] & (mode == MODE_OAM))    |
               (en[3] & coinc);
        irq_stat = line & ~line_q & ~clear;
    end

    always_ff @(posedge clockgb) begin
        if (reset || clear) begin
            line_q <= 1'b0;
        end else begin
            line_q <= line;
        end
    end

endmodule

// File: rtl/ppu_sequencer.sv
// Scanline/frame scheduler with LCDC/STAT/LY/LYC registers and VBLANK/STAT interrupts.
// Define PPU_ACCESS_LOCK_EN to block CPU VRAM/OAM access while the PPU owns them.
module ppu_sequencer
  import ppu_pkg::*;
#(
    parameter int unsigned WIDTH       = 160,
    parameter int unsigned HEIGHT      = 144,
    parameter int unsigned VBL_LINES   = 10,
    parameter int unsigned MODE2_COUNT = 80,
    parameter int unsigned MODE3_COUNT = 172,
    parameter int unsigned MODE0_COUNT = 204
) (
    input  logic        clockgb,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    output logic [1:0]  mode,
    output logic [7:0]  ly,
    output logic [7:0]  x,
    output logic [7:0]  lcdc,
    output logic        irq_vblank,
    output logic        irq_stat,
    output logic        vram_cpu_ok,
    output logic        oam_cpu_ok
);

    localparam logic [8:0] OAM_END  = 9'(MODE2_COUNT - 1);
    localparam logic [8:0] XFER_END = 9'(MODE2_COUNT + MODE3_COUNT - 1);
    localparam logic [8:0] LINE_END = 9'(MODE2_COUNT + MODE3_COUNT + MODE0_COUNT - 1);
    localparam logic [7:0] LY_VBL   = 8'(HEIGHT);
    localparam logic [7:0] LY_LAST  = 8'(HEIGHT + VBL_LINES - 1);
    localparam logic [7:0] X_LAST   = 8'(WIDTH - 1);

    mode_e      mode_q, mode_d;
    logic [8:0] cnt_q, cnt_d;
    logic [7:0] ly_q, ly_d;
    logic [7:0] x_q, x_d;
    logic       vbl_q, vbl_d;
    logic [7:0] lcdc_q;
    logic [3:0] stat_en_q;
    logic [7:0] lyc_q;

    logic       lcd_on_q, lcd_on_d;
    logic       wr_lcdc;
    logic       coinc;

    assign lcd_on_q = lcdc_q[LCDC_ENABLE];
    assign wr_lcdc  = store && (address == ADDR_LCDC);
    // The sequencer reacts to the LCDC value being written, so it is off in the very next cycle.
    assign lcd_on_d = wr_lcdc ? indata[LCDC_ENABLE] : lcd_on_q;
    assign coinc    = (ly_q == lyc_q);

    // State register
    always_ff @(posedge clockgb) begin
        if (reset) begin
            mode_q <= MODE_OAM;
            cnt_q  <= '0;
            ly_q   <= '0;
            x_q    <= '0;
            vbl_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            ly_q   <= ly_d;
            x_q    <= x_d;
            vbl_q  <= vbl_d;
        end
    end

    // Next-state
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q + 9'd1;
        ly_d   = ly_q;
        vbl_d  = 1'b0;
        if (!lcd_on_d) begin
            mode_d = MODE_HBLANK;
            cnt_d  = '0;
            ly_d   = '0;
        end else if (!lcd_on_q) begin
            mode_d = MODE_OAM;
            cnt_d  = '0;
            ly_d   = '0;
        end else begin
            unique case (mode_q)
                MODE_OAM: begin
                    if (cnt_q == OAM_END) mode_d = MODE_XFER;
                end
                MODE_XFER: begin
                    if (cnt_q == XFER_END) mode_d = MODE_HBLANK;
                end
                MODE_HBLANK: begin
                    if (cnt_q == LINE_END) begin
                        cnt_d = '0;
                        ly_d  = ly_q + 8'd1;
                        if (ly_d == LY_VBL) begin
                            mode_d = MODE_VBLANK;
                            vbl_d  = 1'b1;
                        end else begin
                            mode_d = MODE_OAM;
                        end
                    end
                end
                MODE_VBLANK: begin
                    if (cnt_q == LINE_END) begin
                        cnt_d = '0;
                        if (ly_q == LY_LAST) begin
                            ly_d   = '0;
                            mode_d = MODE_OAM;
                        end else begin
                            ly_d = ly_q + 8'd1;
                        end
                    end
                end
            endcase
        end

        x_d = '0;
        if (mode_d == MODE_XFER && mode_q == MODE_XFER) begin
            x_d = (x_q == X_LAST) ? x_q : x_q + 8'd1;
        end
    end

    // Outputs
    always_comb begin
        mode       = mode_q;
        ly         = ly_q;
        x          = x_q;
        lcdc       = lcdc_q;
        irq_vblank = vbl_q;
`ifdef PPU_ACCESS_LOCK_EN
        vram_cpu_ok = !(lcd_on_q && (mode_q == MODE_XFER));
        oam_cpu_ok  = !(lcd_on_q && (mode_q == MODE_XFER || mode_q == MODE_OAM));
`else
        vram_cpu_ok = 1'b1;
        oam_cpu_ok  = 1'b1;
`endif
    end

    // CPU-visible registers; LY is read-only
    always_ff @(posedge clockgb) begin
        if (reset) begin
            lcdc_q    <= LCDC_RESET;
            stat_en_q <= '0;
            lyc_q     <= '0;
        end else if (store) begin
            case (address)
                ADDR_LCDC: lcdc_q    <= indata;
                ADDR_STAT: stat_en_q <= indata[STAT_EN_MSB:STAT_EN_LSB];
                ADDR_LYC:  lyc_q     <= indata;
                default: ;
            endcase
        end
    end

    always_comb begin
        outdata = '0;
        if (load) begin
            case (address)
                ADDR_LCDC: outdata = lcdc_q;
                ADDR_STAT: outdata = {1'b1, stat_en_q, coinc, mode_q};
                ADDR_LY:   outdata = ly_q;
                ADDR_LYC:  outdata = lyc_q;
                default:   outdata = '0;
            endcase
        end
    end

    ppu_stat_irq u_stat_irq (
        .clockgb  (clockgb),
        .reset    (reset),
        .clear    (!lcd_on_q),
        .en       (stat_en_q),
        .mode     (mode_q),
        .coinc    (coinc),
        .irq_stat (irq_stat)
    );

endmodule

// File: tb/tb_ppu_sequencer.sv
// Directed bench for ppu_sequencer: frame timing, registers, interrupts and LCD on/off.
module tb_ppu_sequencer;

    logic        clockgb = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] address = '0;
    logic [7:0]  indata  = '0;
    logic [7:0]  outdata;
    logic        load    = 1'b0;
    logic        store   = 1'b0;
    logic [1:0]  mode;
    logic [7:0]  ly;
    logic [7:0]  x;
    logic [7:0]  lcdc;
    logic        irq_vblank;
    logic        irq_stat;
    logic        vram_cpu_ok;
    logic        oam_cpu_ok;

    int n_vec  = 0;
    int n_miss = 0;

    ppu_sequencer dut (
        .clockgb     (clockgb),
        .reset       (reset),
        .address     (address),
        .indata      (indata),
        .outdata     (outdata),
        .load        (load),
        .store       (store),
        .mode        (mode),
        .ly          (ly),
        .x           (x),
        .lcdc        (lcdc),
        .irq_vblank  (irq_vblank),
        .irq_stat    (irq_stat),
        .vram_cpu_ok (vram_cpu_ok),
        .oam_cpu_ok  (oam_cpu_ok)
    );

    always #5 clockgb = ~clockgb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        address = a;
        indata  = d;
        store   = 1'b1;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        address = a;
        load    = 1'b1;
        #1;
        d    = outdata;
        load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        store = 1'b0;
        load  = 1'b0;
        repeat (2) @(negedge clockgb);
        reset = 1'b0;
    endtask

    int         bad_mode, bad_ly, bad_x, bad_grant, bad_st, bad_off;
    int         n_x3, first_x3, second_x3, n_vbl, vbl_cyc, n_st, st_cyc;
    int         el, pos, em, ex;
    logic [1:0] prev_mode;
    logic [7:0] rd;
    logic       ev, eo;

    initial begin
        // Full frame from reset with hblank+vblank STAT enables
        bad_mode = 0; bad_ly = 0; bad_x = 0; bad_grant = 0; bad_st = 0;
        n_x3 = 0; first_x3 = -1; second_x3 = -1; n_vbl = 0; vbl_cyc = -1; n_st = 0;
        prev_mode = 2'd2;
        do_reset();
        for (int c = 0; c <= 70224; c++) begin
            store = 1'b0;
            el  = (c / 456) % 154;
            pos = c % 456;
            if (el >= 144)     em = 1;
            else if (pos < 80)  em = 2;
            else if (pos < 252) em = 3;
            else                em = 0;
            ex = (em == 3) ? ((pos - 80 > 159) ? 159 : pos - 80) : 0;
            if (mode !== 2'(em)) bad_mode++;
            if (ly !== 8'(el))   bad_ly++;
            if (x !== 8'(ex))    bad_x++;
`ifdef PPU_ACCESS_LOCK_EN
            ev = (em != 3);
            eo = (em != 3) && (em != 2);
`else
            ev = 1'b1;
            eo = 1'b1;
`endif
            if (vram_cpu_ok !== ev || oam_cpu_ok !== eo) bad_grant++;
            if (c > 0 && mode == 2'd3 && prev_mode != 2'd3) begin
                n_x3++;
                if (n_x3 == 1) first_x3 = c;
                if (n_x3 == 2) second_x3 = c;
            end
            if (irq_vblank) begin n_vbl++; vbl_cyc = c; end
            if (irq_stat) begin
                n_st++;
                if (pos != 252 || el >= 144) bad_st++;
            end
            prev_mode = mode;

            if (c == 0) begin
                check("rst_mode", 32'(mode), 32'd2);
                check("rst_ly", 32'(ly), 32'd0);
                check("rst_x", 32'(x), 32'd0);
                check("rst_irq", {30'd0, irq_vblank, irq_stat}, 32'd0);
                check("rst_outdata", 32'(outdata), 32'd0);
                check("rst_lcdc_port", 32'(lcdc), 32'h91);
`ifndef PPU_ACCESS_LOCK_EN
                check("rst_grants", {30'd0, vram_cpu_ok, oam_cpu_ok}, 32'd3);
`endif
                cpu_read(16'hFF40, rd); check("rst_lcdc_rd", 32'(rd), 32'h91);
                cpu_read(16'hFF41, rd); check("rst_stat_rd", 32'(rd), 32'h86);
                cpu_read(16'hFF45, rd); check("rst_lyc_rd", 32'(rd), 32'h00);
            end
            if (c == 1) cpu_write(16'hFF41, 8'h18);
            if (c == 2) cpu_write(16'hFF44, 8'h33);
            if (c == 3) begin
                cpu_read(16'hFF42, rd); check("unmapped_rd", 32'(rd), 32'h00);
                cpu_read(16'hFF44, rd); check("ly_ro_rd", 32'(rd), 32'h00);
                cpu_read(16'hFF41, rd); check("stat_wr_rd", 32'(rd), 32'h9E);
            end
            if (c == 251) check("x_sat_end_m3", 32'(x), 32'd159);
            if (c == 70223) check("ly_last", 32'(ly), 32'd153);
            if (c == 70224) check("ly_wrap", 32'(ly), 32'd0);
            @(negedge clockgb);
        end
        check("frame_mode_seq", bad_mode, 0);
        check("frame_ly_seq", bad_ly, 0);
        check("frame_x_seq", bad_x, 0);
        check("frame_grants", bad_grant, 0);
        check("m3_entries", n_x3, 144);
        check("m3_first", first_x3, 80);
        check("m3_second", second_x3, 536);
        check("vblank_count", n_vbl, 1);
        check("vblank_cycle", vbl_cyc, 65664);
        check("stat_hv_count", n_st, 144);
        check("stat_hv_place", bad_st, 0);

        // LYC coincidence, then LCD off/on
        n_st = 0; st_cyc = -1; bad_off = 0;
        do_reset();
        for (int c = 0; c <= 19500; c++) begin
            store = 1'b0;
            if (c <= 2400 && irq_stat) begin n_st++; st_cyc = c; end
            if (c == 1) cpu_write(16'hFF45, 8'h05);
            if (c == 2) cpu_write(16'hFF41, 8'h40);
            if (c == 2281) begin
                cpu_read(16'hFF41, rd); check("stat_coinc_rd", 32'(rd), 32'hC6);
                cpu_read(16'hFF45, rd); check("lyc_rd", 32'(rd), 32'h05);
            end
            if (c == 2300) cpu_write(16'hFF45, 8'h06);
            if (c == 2301) begin
                cpu_read(16'hFF41, rd); check("lyc_change_rd", 32'(rd), 32'hC2);
            end
            if (c == 2400) begin
                check("coinc_pulses", n_st, 1);
                check("coinc_cycle", st_cyc, 2280);
            end
            if (c == 18340) begin
                check("pre_off_mode", 32'(mode), 32'd3);
                check("pre_off_ly", 32'(ly), 32'd40);
                cpu_write(16'hFF40, 8'h11);
            end
            if (c >= 18341 && c <= 19341) begin
                if (mode !== 2'd0 || ly !== 8'd0 || x !== 8'd0 || irq_vblank || irq_stat ||
                    !vram_cpu_ok || !oam_cpu_ok) bad_off++;
            end
            if (c == 18341) begin
                check("off_mode", 32'(mode), 32'd0);
                check("off_ly", 32'(ly), 32'd0);
                cpu_read(16'hFF40, rd); check("off_lcdc_rd", 32'(rd), 32'h11);
            end
            if (c == 19341) begin
                check("off_held", bad_off, 0);
                cpu_write(16'hFF40, 8'h91);
            end
            if (c == 19342) begin
                check("on_mode", 32'(mode), 32'd2);
                check("on_ly", 32'(ly), 32'd0);
                check("on_lcdc_port", 32'(lcdc), 32'h91);
            end
            if (c == 19421) check("on_pre_m3", 32'(mode), 32'd2);
            if (c == 19422) begin
                check("on_m3_entry", 32'(mode), 32'd3);
                check("on_m3_x0", 32'(x), 32'd0);
            end
            if (c == 19423) check("on_m3_x1", 32'(x), 32'd1);
            @(negedge clockgb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
